// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the memory-side pipeline stages.
// Holds the address/data widths, the default halt encoding and the fetch FSM encoding.
package instruction_fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam word_t HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    LATCH  = 3'd2,
    HOLD   = 3'd3,
    HALTED = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch stage's control, instruction-memory and decode-side signals.
// master = fetch unit, slave = the environment (memory, decode, branch logic).
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic  enable;
  logic  redirect_valid;
  addr_t redirect_pc;
  logic  imem_rd;
  logic  imem_wn;
  addr_t imem_address;
  word_t imem_read_data;
  logic  out_valid;
  logic  out_ready;
  word_t out_instr;
  addr_t out_pc;
  logic  halted;

  modport master (
    input  enable, redirect_valid, redirect_pc, imem_read_data, out_ready,
    output imem_rd, imem_wn, imem_address, out_valid, out_instr, out_pc, halted
  );

  modport slave (
    output enable, redirect_valid, redirect_pc, imem_read_data, out_ready,
    input  imem_rd, imem_wn, imem_address, out_valid, out_instr, out_pc, halted
  );

endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: one word per three cycles into a valid/ready decode port,
// with redirect, halt-word detection and 16-bit wrapping PC.
//
// state  | meaning
// IDLE   | waiting for enable, no memory traffic
// ISSUE  | imem_rd asserted at pc
// LATCH  | memory data returned, captured into the output register
// HOLD   | out_valid high until decode accepts
// HALTED | halt word delivered, waiting for redirect or reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter addr_t RESET_PC  = 16'h0000,
  parameter word_t HALT_WORD = HALT_WORD_DEFAULT
) (
  input logic          clk,
  input logic          reset_n,
  instruction_fetch_if.master bus
);

  fetch_state_e state, state_nxt;
  addr_t        pc, pc_nxt;
  logic         out_valid_q, out_valid_nxt;
  word_t        out_instr_q, out_instr_nxt;
  addr_t        out_pc_q, out_pc_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      out_valid_q <= out_valid_nxt;
      out_instr_q <= out_instr_nxt;
      out_pc_q    <= out_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    out_valid_nxt = out_valid_q;
    out_instr_nxt = out_instr_q;
    out_pc_nxt    = out_pc_q;

    case (state)
      IDLE: begin
        if (bus.enable) state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = LATCH;
      end
      LATCH: begin
        out_instr_nxt = bus.imem_read_data;
        out_pc_nxt    = pc;
        out_valid_nxt = 1'b1;
        pc_nxt        = pc + addr_t'(1);
        state_nxt     = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_nxt = 1'b0;
          if (out_instr_q == HALT_WORD) state_nxt = HALTED;
          else if (bus.enable)          state_nxt = ISSUE;
          else                          state_nxt = IDLE;
        end
      end
      HALTED: begin
        state_nxt = HALTED;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Redirect overrides everything; a same-cycle transfer still completes since
    // out_valid drops, but the captured word and halt detection are discarded.
    if (bus.redirect_valid) begin
      pc_nxt        = bus.redirect_pc;
      out_valid_nxt = 1'b0;
      out_instr_nxt = out_instr_q;
      out_pc_nxt    = out_pc_q;
      state_nxt     = bus.enable ? ISSUE : IDLE;
    end
  end

  assign bus.imem_rd      = reset_n && (state == ISSUE);
  assign bus.imem_wn      = 1'b0;
  assign bus.imem_address = pc;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_instr    = out_instr_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.halted       = reset_n && (state == HALTED);

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized run
// scored against a model that tracks only "next address to be delivered".
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  word_t mem [0:65535];

  instruction_fetch_if bus();
  instruction_fetch_if bus2();

  instruction_fetch #(.RESET_PC(16'h0000)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  instruction_fetch #(.RESET_PC(16'hFFFF)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns data the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) bus.imem_read_data <= bus.imem_rd ? mem[bus.imem_address] : $urandom;
  always @(posedge clk) bus2.imem_read_data <= bus2.imem_rd ? mem[bus2.imem_address] : $urandom;

  task automatic fill_mem();
    for (int i = 0; i < 65536; i++) begin
      mem[i] = $urandom;
      if (mem[i] == HALT_WORD_DEFAULT) mem[i] = 32'h0;
    end
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;
  endtask

  task automatic do_reset(input logic en);
    @(negedge clk);
    reset_n = 1'b0;
    bus.enable = en;
    bus.redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.enable = 1'b0;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL reset_imem_rd got=%b exp=0", bus.imem_rd); end
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
    checks++; if (bus.out_pc !== 16'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
    checks++; if (bus.imem_address !== 16'h0000) begin failures++; $display("FAIL reset_pc got=%h exp=0000", bus.imem_address); end
    checks++; if (bus2.imem_address !== 16'hFFFF) begin failures++; $display("FAIL reset_pc2 got=%h exp=ffff", bus2.imem_address); end
    checks++; if (bus.imem_wn !== 1'b0) begin failures++; $display("FAIL reset_imem_wn got=%b exp=0", bus.imem_wn); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL idle_no_enable_rd got=%b exp=0", bus.imem_rd); end
  endtask

  task automatic test_sequential();
    word_t exp_w [3];
    int n = 0;
    int t_issue = -1;
    int t_valid [3];
    exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33;
    bus.out_ready = 1'b1;
    do_reset(1'b1);
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      if (bus.imem_rd && t_issue < 0) t_issue = cyc;
      if (bus.out_valid) begin
        checks++; if (bus.out_instr !== exp_w[n]) begin failures++; $display("FAIL seq_instr[%0d] got=%h exp=%h", n, bus.out_instr, exp_w[n]); end
        checks++; if (bus.out_pc !== addr_t'(n)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%0d", n, bus.out_pc, n); end
        t_valid[n] = cyc;
        n++;
      end
    end
    checks++;
    if (n < 3) begin
      failures++; $display("FAIL seq_timeout got=%0d exp=3 deliveries", n);
    end else begin
      checks++; if (t_valid[0] - t_issue != 2) begin failures++; $display("FAIL seq_latency got=%0d exp=2", t_valid[0] - t_issue); end
      checks++; if (t_valid[1] - t_valid[0] != 3) begin failures++; $display("FAIL seq_gap01 got=%0d exp=3", t_valid[1] - t_valid[0]); end
      checks++; if (t_valid[2] - t_valid[1] != 3) begin failures++; $display("FAIL seq_gap12 got=%0d exp=3", t_valid[2] - t_valid[1]); end
    end
  endtask

  task automatic test_stall();
    logic found = 1'b0;
    bus.out_ready = 1'b1;
    do_reset(1'b1);
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_pc == 16'd4) found = 1'b1;
    end
    bus.out_ready = 1'b0;
    checks++;
    if (!found) begin
      failures++; $display("FAIL stall_timeout got=no_pc4 exp=pc4");
      return;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, bus.out_valid); end
      checks++; if (bus.out_pc !== 16'd4) begin failures++; $display("FAIL stall_pc[%0d] got=%h exp=4", k, bus.out_pc); end
      checks++; if (bus.out_instr !== mem[4]) begin failures++; $display("FAIL stall_instr[%0d] got=%h exp=%h", k, bus.out_instr, mem[4]); end
      checks++; if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL stall_rd[%0d] got=%b exp=0", k, bus.imem_rd); end
      checks++; if (bus.imem_address !== 16'd5) begin failures++; $display("FAIL stall_addr[%0d] got=%h exp=5", k, bus.imem_address); end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stall_accept got=%b exp=0", bus.out_valid); end
    checks++; if (!(bus.imem_rd === 1'b1 && bus.imem_address === 16'd5)) begin
      failures++; $display("FAIL stall_next_fetch got=rd%b@%h exp=rd1@0005", bus.imem_rd, bus.imem_address);
    end
  endtask

  task automatic test_redirect();
    logic found = 1'b0;
    bus.out_ready = 1'b1;
    do_reset(1'b1);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.imem_rd) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL redir_timeout got=no_issue exp=issue"); return; end
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0100;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_drop got=%b exp=0", bus.out_valid); end
    checks++; if (!(bus.imem_rd === 1'b1 && bus.imem_address === 16'h0100)) begin
      failures++; $display("FAIL redir_fetch got=rd%b@%h exp=rd1@0100", bus.imem_rd, bus.imem_address);
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL redir_valid_timeout got=none exp=delivery"); return; end
    checks++; if (bus.out_pc !== 16'h0100) begin failures++; $display("FAIL redir_pc got=%h exp=0100", bus.out_pc); end
    checks++; if (bus.out_instr !== mem[16'h0100]) begin failures++; $display("FAIL redir_instr got=%h exp=%h", bus.out_instr, mem[16'h0100]); end
  endtask

  task automatic test_halt();
    logic found = 1'b0;
    mem[7] = HALT_WORD_DEFAULT;
    bus.out_ready = 1'b1;
    do_reset(1'b1);
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_pc == 16'd7) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL halt_timeout got=no_pc7 exp=pc7"); mem[7] = 32'h7777; return; end
    checks++; if (bus.out_instr !== HALT_WORD_DEFAULT) begin failures++; $display("FAIL halt_word got=%h exp=ffffffff", bus.out_instr); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++; if ({bus.halted, bus.imem_rd, bus.out_valid} !== 3'b100) begin
        failures++; $display("FAIL halt_state[%0d] got=halted%b rd%b valid%b exp=halted1 rd0 valid0", k, bus.halted, bus.imem_rd, bus.out_valid);
      end
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 16'h0000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_exit got=%b exp=0", bus.halted); end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL halt_resume_timeout got=none exp=delivery"); end
    else begin
      checks++; if (bus.out_pc !== 16'h0000 || bus.out_instr !== mem[0]) begin
        failures++; $display("FAIL halt_resume got=%h:%h exp=0000:%h", bus.out_pc, bus.out_instr, mem[0]);
      end
    end
    mem[7] = 32'h7777;
  endtask

  task automatic test_wrap();
    addr_t exp_pc [2];
    int n = 0;
    exp_pc[0] = 16'hFFFF; exp_pc[1] = 16'h0000;
    do_reset(1'b1);
    for (int k = 0; k < 30 && n < 2; k++) begin
      @(negedge clk);
      if (bus2.out_valid) begin
        checks++; if (bus2.out_pc !== exp_pc[n]) begin failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", n, bus2.out_pc, exp_pc[n]); end
        checks++; if (bus2.out_instr !== mem[exp_pc[n]]) begin failures++; $display("FAIL wrap_instr[%0d] got=%h exp=%h", n, bus2.out_instr, mem[exp_pc[n]]); end
        n++;
      end
    end
    checks++; if (n < 2) begin failures++; $display("FAIL wrap_timeout got=%0d exp=2", n); end
  endtask

  task automatic test_reset_in_hold();
    logic found = 1'b0;
    bus.out_ready = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.out_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rsthold_timeout got=none exp=hold"); return; end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rsthold_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.imem_address !== 16'h0000) begin failures++; $display("FAIL rsthold_pc got=%h exp=0000", bus.imem_address); end
    checks++; if (bus.imem_rd !== 1'b0 || bus.halted !== 1'b0) begin failures++; $display("FAIL rsthold_strobes got=rd%b halted%b exp=0 0", bus.imem_rd, bus.halted); end
    reset_n = 1'b1;
    bus.enable = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++; if (bus.imem_rd !== 1'b0) begin failures++; $display("FAIL rsthold_idle got=%b exp=0", bus.imem_rd); end
    end
    bus.enable = 1'b1;
    @(negedge clk);
    checks++; if (!(bus.imem_rd === 1'b1 && bus.imem_address === 16'h0000)) begin
      failures++; $display("FAIL rsthold_refetch got=rd%b@%h exp=rd1@0000", bus.imem_rd, bus.imem_address);
    end
  endtask

  task automatic test_random();
    addr_t exp_pc = 16'h0000;
    logic  hold_pending = 1'b0;
    addr_t held_pc = '0;
    word_t held_instr = '0;
    int    nx = 0;
    bus.out_ready = 1'b0;
    do_reset(1'b1);
    for (int k = 0; k < 800; k++) begin
      checks++; if (bus.imem_wn !== 1'b0) begin failures++; $display("FAIL rnd_wn got=%b exp=0", bus.imem_wn); end
      if (bus.imem_rd) begin
        checks++; if (bus.imem_address !== exp_pc) begin failures++; $display("FAIL rnd_fetch_addr got=%h exp=%h", bus.imem_address, exp_pc); end
      end
      if (hold_pending) begin
        checks++; if (!(bus.out_valid === 1'b1 && bus.out_pc === held_pc && bus.out_instr === held_instr)) begin
          failures++; $display("FAIL rnd_hold got=%b:%h:%h exp=1:%h:%h", bus.out_valid, bus.out_pc, bus.out_instr, held_pc, held_instr);
        end
      end
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      bus.redirect_pc = addr_t'($urandom);
      if (bus.out_valid && bus.out_ready) begin
        checks++; if (bus.out_pc !== exp_pc || bus.out_instr !== mem[exp_pc]) begin
          failures++; $display("FAIL rnd_xfer got=%h:%h exp=%h:%h", bus.out_pc, bus.out_instr, exp_pc, mem[exp_pc]);
        end
        exp_pc = exp_pc + 16'd1;
        nx++;
      end
      hold_pending = bus.out_valid && !bus.out_ready && !bus.redirect_valid;
      held_pc = bus.out_pc;
      held_instr = bus.out_instr;
      if (bus.redirect_valid) exp_pc = bus.redirect_pc;
      @(negedge clk);
    end
    bus.redirect_valid = 1'b0;
    checks++; if (nx < 60) begin failures++; $display("FAIL rnd_throughput got=%0d exp>=60", nx); end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.out_ready = 1'b0;
    bus2.enable = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc = '0;
    bus2.out_ready = 1'b1;
    fill_mem();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_in_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
